// File: rtl/mem_stage_lsu_if.sv
// Data-bus bundle between the MEM-stage LSU (master) and the data memory (slave).
// Handshake: the master raises bus_req_o and holds addr/we/be/wdata stable until the
// slave answers with a one-cycle bus_ack_i (read data valid in that same cycle).
interface mem_stage_lsu_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one bus transaction per load/store, pipeline stall until
// completion, byte-lane store formatting, load alignment/extension, misalign and timeout flags.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid_mem_i,
  input  logic                  dram_we_mem_i,
  input  logic                  is_load_mem_i,
  input  logic [1:0]            mem_type_mem_i,
  input  logic                  mem_unsigned_mem_i,
  input  logic [31:0]           alu_result_mem_i,
  input  logic [31:0]           rD2_mem_i,
  mem_stage_lsu_if.master       bus,
  output logic [31:0]           load_data_o,
  output logic                  lsu_stall_o,
  output logic                  misaligned_o,
  output logic                  bus_err_o,
  output logic [1:0]            state_dbg_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          req_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic          load_q;
  logic [1:0]    lane_q;
  logic          half_q;
  logic          word_q;
  logic          uns_q;
  logic [31:0]   load_data_q;
  logic          mis_q;
  logic          err_q;

  logic          access;
  logic          is_half;
  logic          is_word;
  logic          misaligned;
  logic [1:0]    a_lo;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;

  // Request decode; type 2'b11 falls into the word path through mem_type[1].
  always_comb begin
    access     = instr_valid_mem_i & (dram_we_mem_i | is_load_mem_i);
    a_lo       = alu_result_mem_i[1:0];
    is_half    = (mem_type_mem_i == 2'b01);
    is_word    = mem_type_mem_i[1];
    misaligned = (is_half & a_lo[0]) | (is_word & (a_lo != 2'b00));
    be_d       = 4'b0000;
    wdata_d    = 32'h0;
    if (is_word) begin
      be_d    = 4'hF;
      wdata_d = rD2_mem_i;
    end else if (is_half) begin
      be_d    = 4'b0011 << a_lo;
      wdata_d = {2{rD2_mem_i[15:0]}};
    end else begin
      be_d    = 4'b0001 << a_lo;
      wdata_d = {4{rD2_mem_i[7:0]}};
    end
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Lane select uses the attributes captured at BUSY entry, not the live inputs.
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = bus.bus_rdata_i[7:0];
      2'd1:    byte_sel = bus.bus_rdata_i[15:8];
      2'd2:    byte_sel = bus.bus_rdata_i[23:16];
      default: byte_sel = bus.bus_rdata_i[31:24];
    endcase
    half_sel = lane_q[1] ? bus.bus_rdata_i[31:16] : bus.bus_rdata_i[15:0];
    if (word_q) begin
      load_ext = bus.bus_rdata_i;
    end else if (half_q) begin
      load_ext = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
    end else begin
      load_ext = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      load_q      <= 1'b0;
      lane_q      <= 2'd0;
      half_q      <= 1'b0;
      word_q      <= 1'b0;
      uns_q       <= 1'b0;
      load_data_q <= 32'h0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (access) begin
            if (misaligned) begin
              state_q <= S_DONE;
              mis_q   <= 1'b1;
            end else begin
              state_q <= S_BUSY;
              req_q   <= 1'b1;
              cnt_q   <= '0;
              we_q    <= dram_we_mem_i;
              addr_q  <= {alu_result_mem_i[31:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
              load_q  <= ~dram_we_mem_i;
              lane_q  <= a_lo;
              half_q  <= is_half;
              word_q  <= is_word;
              uns_q   <= mem_unsigned_mem_i;
            end
          end
        end
        S_BUSY: begin
          // An ack on the final budget cycle still counts as a completion.
          if (bus.bus_ack_i) begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            if (load_q) begin
              load_data_q <= load_ext;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.bus_req_o   = req_q;
  assign bus.bus_we_o    = we_q;
  assign bus.bus_addr_o  = addr_q;
  assign bus.bus_be_o    = be_q;
  assign bus.bus_wdata_o = wdata_q;

  // Stall is low in DONE so the pipeline can advance past the finished access.
  assign lsu_stall_o  = ((state_q == S_IDLE) & access) | (state_q == S_BUSY);
  assign load_data_o  = load_data_q;
  assign misaligned_o = mis_q;
  assign bus_err_o    = err_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed vector table, hand sequences for back-to-back and
// reset-during-BUSY, then random transactions against a spec-level model.
module tb_mem_stage_lsu;
  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        instr_valid_mem_i;
  logic        dram_we_mem_i;
  logic        is_load_mem_i;
  logic [1:0]  mem_type_mem_i;
  logic        mem_unsigned_mem_i;
  logic [31:0] alu_result_mem_i;
  logic [31:0] rD2_mem_i;
  logic [31:0] load_data_o;
  logic        lsu_stall_o;
  logic        misaligned_o;
  logic        bus_err_o;
  logic [1:0]  state_dbg_o;

  mem_stage_lsu_if bif ();

  mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                (clk),
    .rst                (rst),
    .instr_valid_mem_i  (instr_valid_mem_i),
    .dram_we_mem_i      (dram_we_mem_i),
    .is_load_mem_i      (is_load_mem_i),
    .mem_type_mem_i     (mem_type_mem_i),
    .mem_unsigned_mem_i (mem_unsigned_mem_i),
    .alu_result_mem_i   (alu_result_mem_i),
    .rD2_mem_i          (rD2_mem_i),
    .bus                (bif),
    .load_data_o        (load_data_o),
    .lsu_stall_o        (lsu_stall_o),
    .misaligned_o       (misaligned_o),
    .bus_err_o          (bus_err_o),
    .state_dbg_o        (state_dbg_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_ld;

  typedef struct {
    logic        valid;
    logic        we;
    logic        ld;
    logic [1:0]  mtype;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] rd2;
    logic [31:0] rdata;
    int          ack_delay;
    bit          no_ack;
    int          exp_stall;
    int          exp_req;
    int          exp_mis;
    int          exp_err;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    bit          chk_wdata;
    logic [31:0] exp_ld;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic valid, logic we, logic ld, logic [1:0] mt, logic uns,
                              logic [31:0] addr, logic [31:0] rd2, logic [31:0] rdata,
                              int dly, bit noack, int st, int rq, int ms, int er,
                              logic [3:0] be, logic [31:0] wd, logic [31:0] eld);
    vec_t v;
    v.valid = valid; v.we = we; v.ld = ld; v.mtype = mt; v.uns = uns;
    v.addr = addr; v.rd2 = rd2; v.rdata = rdata; v.ack_delay = dly; v.no_ack = noack;
    v.exp_stall = st; v.exp_req = rq; v.exp_mis = ms; v.exp_err = er;
    v.exp_we = we; v.exp_be = be; v.exp_wdata = wd; v.chk_wdata = we; v.exp_ld = eld;
    return v;
  endfunction

  // Reference model: size/offset arithmetic straight from the access rules.
  function automatic vec_t model(input vec_t v, input logic [31:0] prev);
    int sz;
    int off;
    bit acc;
    bit mis;
    bit acked;
    logic [31:0] raw;
    logic [31:0] mask;
    logic [31:0] val;
    sz    = (v.mtype == 2'd0) ? 1 : (v.mtype == 2'd1) ? 2 : 4;
    off   = int'(v.addr[1:0]);
    acc   = v.valid && (v.we || v.ld);
    mis   = acc && ((off % sz) != 0);
    acked = acc && !mis && !v.no_ack && (v.ack_delay < TO);
    v.exp_mis = mis ? 1 : 0;
    v.exp_err = (acc && !mis && !acked) ? 1 : 0;
    if (!acc) begin
      v.exp_stall = 0; v.exp_req = 0;
    end else if (mis) begin
      v.exp_stall = 1; v.exp_req = 0;
    end else if (!acked) begin
      v.exp_stall = 1 + TO; v.exp_req = TO;
    end else begin
      v.exp_stall = v.ack_delay + 2; v.exp_req = v.ack_delay + 1;
    end
    v.exp_we = v.we;
    v.exp_be = 4'(((1 << sz) - 1) << off);
    for (int i = 0; i < 4; i++) v.exp_wdata[8*i +: 8] = v.rd2[8*(i % sz) +: 8];
    v.chk_wdata = v.we;
    raw = v.rdata >> (8 * off);
    if (sz == 4) begin
      val = raw;
    end else begin
      mask = (32'd1 << (8 * sz)) - 32'd1;
      val  = raw & mask;
      if (!v.uns && raw[8*sz-1]) val = val | ~mask;
    end
    v.exp_ld = (acked && !v.we) ? val : prev;
    return v;
  endfunction

  // driver: applies one instruction and plays the memory side until DONE
  task automatic run_txn(input vec_t v, input string tag);
    int stall_n = 0, req_n = 0, mis_n = 0, err_n = 0, waited = 0, cyc = 0;
    bit seen_stall = 0, fin = 0, stable = 1;
    logic [31:0] s_addr = 0, s_wdata = 0, e_ld;
    logic [3:0] s_be = 0;
    logic s_we = 0;
    @(negedge clk);
    instr_valid_mem_i = v.valid; dram_we_mem_i = v.we; is_load_mem_i = v.ld;
    mem_type_mem_i = v.mtype; mem_unsigned_mem_i = v.uns;
    alu_result_mem_i = v.addr; rD2_mem_i = v.rd2;
    while (!fin && cyc < 64) begin
      #1;
      if (lsu_stall_o) begin stall_n++; seen_stall = 1; end
      if (bif.bus_req_o) begin
        if (req_n == 0) begin
          s_addr = bif.bus_addr_o; s_be = bif.bus_be_o; s_we = bif.bus_we_o; s_wdata = bif.bus_wdata_o;
        end else if (s_addr !== bif.bus_addr_o || s_be !== bif.bus_be_o ||
                     s_we !== bif.bus_we_o || s_wdata !== bif.bus_wdata_o) begin
          stable = 0;
        end
        req_n++;
      end
      if (misaligned_o) mis_n++;
      if (bus_err_o) err_n++;
      if (bif.bus_req_o && !v.no_ack && waited == v.ack_delay) begin
        bif.bus_ack_i = 1'b1; bif.bus_rdata_i = v.rdata;
      end else begin
        bif.bus_ack_i = 1'b0; bif.bus_rdata_i = $urandom;
      end
      if (bif.bus_req_o) waited++;
      if ((seen_stall && !lsu_stall_o) || (!seen_stall && cyc >= 2)) fin = 1;
      else @(negedge clk);
      cyc++;
    end
    bif.bus_ack_i = 1'b0;
    if (!fin) chk({tag, " completion timeout"}, 32'd0, 32'd1);
    chk({tag, " stall cycles"}, 32'(stall_n), 32'(v.exp_stall));
    chk({tag, " req cycles"}, 32'(req_n), 32'(v.exp_req));
    chk({tag, " misaligned pulses"}, 32'(mis_n), 32'(v.exp_mis));
    chk({tag, " bus_err pulses"}, 32'(err_n), 32'(v.exp_err));
    e_ld = exp_q.pop_front();
    chk({tag, " load_data"}, load_data_o, e_ld);
    if (v.exp_req > 0 && req_n > 0) begin
      chk({tag, " addr"}, s_addr, v.addr & 32'hFFFF_FFFC);
      chk({tag, " be"}, 32'(s_be), 32'(v.exp_be));
      chk({tag, " we"}, 32'(s_we), 32'(v.exp_we));
      chk({tag, " req stable"}, 32'(stable), 32'd1);
      if (v.chk_wdata) chk({tag, " wdata"}, s_wdata, v.exp_wdata);
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    instr_valid_mem_i = 1'b0;
    #1;
    chk({tag, " idle outputs"}, {28'h0, lsu_stall_o, bif.bus_req_o, misaligned_o, bus_err_o}, 32'h0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    instr_valid_mem_i = 0; dram_we_mem_i = 0; is_load_mem_i = 0; mem_type_mem_i = 0;
    mem_unsigned_mem_i = 0; alu_result_mem_i = 0; rD2_mem_i = 0;
    bif.bus_ack_i = 0; bif.bus_rdata_i = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset bus", {bif.bus_req_o, bif.bus_we_o, bif.bus_be_o, 26'h0}, 32'h0);
    chk("reset addr", bif.bus_addr_o, 32'h0);
    chk("reset wdata", bif.bus_wdata_o, 32'h0);
    chk("reset load_data", load_data_o, 32'h0);
    chk("reset flags", {28'h0, lsu_stall_o, misaligned_o, bus_err_o, 1'b0}, 32'h0);
    chk("reset state", 32'(state_dbg_o), 32'd0);
    rst = 1'b0;

    //         v  we ld mt    u  addr          rd2           rdata         dly na st rq ms er be       wdata         load_data
    tbl[0]  = mk(1, 1, 0, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 2, 1, 0, 0, 4'hF,    32'hDEADBEEF, 32'h0);
    tbl[1]  = mk(1, 0, 1, 2'd0, 0, 32'h203, 32'h0,        32'h80FFFFFF, 1, 0, 3, 2, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80);
    tbl[2]  = mk(1, 0, 1, 2'd0, 1, 32'h203, 32'h0,        32'h80FFFFFF, 0, 0, 2, 1, 0, 0, 4'b1000, 32'h0,        32'h00000080);
    tbl[3]  = mk(1, 1, 0, 2'd1, 0, 32'h102, 32'h1234ABCD, 32'h0,        0, 0, 2, 1, 0, 0, 4'b1100, 32'hABCDABCD, 32'h00000080);
    tbl[4]  = mk(1, 0, 1, 2'd2, 0, 32'h101, 32'h0,        32'h0,        0, 0, 1, 0, 1, 0, 4'h0,    32'h0,        32'h00000080);
    tbl[5]  = mk(1, 0, 1, 2'd2, 0, 32'h300, 32'h0,        32'h0,        0, 1, 5, 4, 0, 1, 4'hF,    32'h0,        32'h00000080);
    tbl[6]  = mk(1, 0, 1, 2'd1, 0, 32'h302, 32'h0,        32'h80017FFF, 2, 0, 4, 3, 0, 0, 4'b1100, 32'h0,        32'hFFFF8001);
    tbl[7]  = mk(1, 0, 1, 2'd1, 1, 32'h300, 32'h0,        32'h8001F00F, 0, 0, 2, 1, 0, 0, 4'b0011, 32'h0,        32'h0000F00F);
    tbl[8]  = mk(1, 1, 0, 2'd0, 0, 32'h001, 32'h000000A5, 32'h0,        3, 0, 5, 4, 0, 0, 4'b0010, 32'hA5A5A5A5, 32'h0000F00F);
    tbl[9]  = mk(1, 1, 0, 2'd1, 0, 32'h003, 32'h0,        32'h0,        0, 0, 1, 0, 1, 0, 4'h0,    32'h0,        32'h0000F00F);
    tbl[10] = mk(0, 1, 0, 2'd2, 0, 32'h104, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0, 4'h0,    32'h0,        32'h0000F00F);
    tbl[11] = mk(1, 1, 1, 2'd2, 0, 32'h204, 32'h11223344, 32'hFFFFFFFF, 1, 0, 3, 2, 0, 0, 4'hF,    32'h11223344, 32'h0000F00F);
    tbl[12] = mk(1, 0, 1, 2'd3, 0, 32'h400, 32'h0,        32'hCAFEF00D, 0, 0, 2, 1, 0, 0, 4'hF,    32'h0,        32'hCAFEF00D);
    tbl[13] = mk(1, 0, 1, 2'd0, 0, 32'h200, 32'h0,        32'h0000007F, 0, 0, 2, 1, 0, 0, 4'b0001, 32'h0,        32'h0000007F);

    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(tbl[i].exp_ld);
      run_txn(tbl[i], $sformatf("row%0d", i));
      idle_cycle($sformatf("row%0d", i));
    end

    // back-to-back LW (ack delay 0) then SW (ack delay 3)
    v = mk(1, 0, 1, 2'd2, 0, 32'h600, 32'h0, 32'h0BADF00D, 0, 0, 2, 1, 0, 0, 4'hF, 32'h0, 32'h0BADF00D);
    exp_q.push_back(v.exp_ld);
    run_txn(v, "b2b_lw");
    v = mk(1, 1, 0, 2'd2, 0, 32'h604, 32'h55AA33CC, 32'h0, 3, 0, 5, 4, 0, 0, 4'hF, 32'h55AA33CC, 32'h0BADF00D);
    exp_q.push_back(v.exp_ld);
    run_txn(v, "b2b_sw");
    idle_cycle("b2b");

    // reset while BUSY, then a late ack
    begin
      bit got_req = 0;
      @(negedge clk);
      instr_valid_mem_i = 1; dram_we_mem_i = 0; is_load_mem_i = 1; mem_type_mem_i = 2'd2;
      alu_result_mem_i = 32'h500;
      for (int c = 0; c < 8 && !got_req; c++) begin
        #1;
        if (bif.bus_req_o) got_req = 1;
        else @(negedge clk);
      end
      chk("rst_busy req seen", 32'(got_req), 32'd1);
      rst = 1'b1; instr_valid_mem_i = 1'b0;
      @(negedge clk); #1;
      chk("rst_busy req", 32'(bif.bus_req_o), 32'd0);
      chk("rst_busy state", 32'(state_dbg_o), 32'd0);
      chk("rst_busy load_data", load_data_o, 32'h0);
      rst = 1'b0; bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'hFFFFFFFF;
      @(negedge clk); #1;
      bif.bus_ack_i = 1'b0;
      chk("late ack req", 32'(bif.bus_req_o), 32'd0);
      chk("late ack state", 32'(state_dbg_o), 32'd0);
      chk("late ack load_data", load_data_o, 32'h0);
      chk("late ack stall", 32'(lsu_stall_o), 32'd0);
      model_ld = 32'h0;
    end

    // random transactions against the reference model
    for (int n = 0; n < 80; n++) begin
      v.valid = ($urandom_range(0, 9) != 0);
      v.we = 1'($urandom_range(0, 1));
      v.ld = v.we ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) != 0);
      v.mtype = 2'($urandom_range(0, 3));
      v.uns = 1'($urandom_range(0, 1));
      v.addr = $urandom;
      if ($urandom_range(0, 2) != 0) v.addr[1:0] = (v.mtype == 2'd0) ? v.addr[1:0] :
                                                   (v.mtype == 2'd1) ? {v.addr[1], 1'b0} : 2'b00;
      v.rd2 = $urandom;
      v.rdata = $urandom;
      v.ack_delay = $urandom_range(0, 5);
      v.no_ack = ($urandom_range(0, 9) == 0);
      v = model(v, model_ld);
      exp_q.push_back(v.exp_ld);
      run_txn(v, $sformatf("rnd%0d", n));
      model_ld = v.exp_ld;
      if ($urandom_range(0, 1) != 0) idle_cycle($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
